// File: rtl/rv32_alu_pkg.sv
// Shared definitions for the RV32I execute-stage ALU: datapath width,
// ALUcntl operation codes and RV32I branch funct3 codes.
// Optional feature macro used across this slice: ALU_FLAGS_EN.
package alu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_XOR  = 4'b0010,
      ALU_SLL  = 4'b0011,
      ALU_SRL  = 4'b0100,
      ALU_SRA  = 4'b0101,
      ALU_ADD  = 4'b0110,
      ALU_SUB  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_SLTU = 4'b1001
   } alu_op_e;

   typedef enum logic [2:0] {
      BR_BEQ  = 3'b000,
      BR_BNE  = 3'b001,
      BR_BLT  = 3'b100,
      BR_BGE  = 3'b101,
      BR_BLTU = 3'b110,
      BR_BGEU = 3'b111
   } br_funct_e;

endpackage

// File: rtl/rv32_alu_if.sv
// Operand/result bundle between the decode stage (master) and the ALU (slave).
// With ALU_FLAGS_EN defined the bundle also carries the zero/negative flags.
interface rv32_alu_if;
   import alu_pkg::*;

   logic            in_valid;
   logic [2:0]      funct;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic [3:0]      ALUcntl;
   logic            out_valid;
   logic [XLEN-1:0] ALUResult;
   logic            ExeBranch;
`ifdef ALU_FLAGS_EN
   logic            zero;
   logic            negative;
`endif

   modport master (
      output in_valid, funct, op1, op2, ALUcntl,
`ifdef ALU_FLAGS_EN
      input  zero, negative,
`endif
      input  out_valid, ALUResult, ExeBranch
   );

   modport slave (
      input  in_valid, funct, op1, op2, ALUcntl,
`ifdef ALU_FLAGS_EN
      output zero, negative,
`endif
      output out_valid, ALUResult, ExeBranch
   );

endinterface

// File: rtl/rv32_alu_branch_cmp.sv
// Branch condition evaluator. Compares the operands directly rather than
// looking at the sign of op1-op2, so signed compares cannot be fooled by
// subtraction overflow. Unused funct3 codes never take the branch.
module alu_branch_cmp
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   input  logic [2:0]      funct,
   output logic            take
);

   // Select the comparison named by funct3.
   always_comb begin
      take = 1'b0;
      case (funct)
         BR_BEQ:  take = (op1 == op2);
         BR_BNE:  take = (op1 != op2);
         BR_BLT:  take = ($signed(op1) <  $signed(op2));
         BR_BGE:  take = ($signed(op1) >= $signed(op2));
         BR_BLTU: take = (op1 <  op2);
         BR_BGEU: take = (op1 >= op2);
         default: take = 1'b0;
      endcase
   end

endmodule

// File: rtl/rv32_alu.sv
// Registered RV32I execute-stage ALU with one-cycle latency.
// ALUResult/ExeBranch only change on cycles with in_valid; out_valid marks
// the cycle after a valid input. Define ALU_FLAGS_EN to add registered
// zero/negative flags derived from the result.
module rv32_alu
   import alu_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   rv32_alu_if.slave bus
);

   logic [XLEN-1:0] result_next;
   logic [4:0]      shamt;
   logic            take;
   logic            branch_next;

   // Only the low five bits of op2 form the shift amount.
   assign shamt = bus.op2[4:0];

   // Result mux; reserved encodings produce zero.
   always_comb begin
      result_next = '0;
      case (bus.ALUcntl)
         ALU_AND:  result_next = bus.op1 & bus.op2;
         ALU_OR:   result_next = bus.op1 | bus.op2;
         ALU_XOR:  result_next = bus.op1 ^ bus.op2;
         ALU_SLL:  result_next = bus.op1 << shamt;
         ALU_SRL:  result_next = bus.op1 >> shamt;
         ALU_SRA:  result_next = $unsigned($signed(bus.op1) >>> shamt);
         ALU_ADD:  result_next = bus.op1 + bus.op2;
         ALU_SUB:  result_next = bus.op1 - bus.op2;
         ALU_SLT:  result_next = {{(XLEN-1){1'b0}}, ($signed(bus.op1) < $signed(bus.op2))};
         ALU_SLTU: result_next = {{(XLEN-1){1'b0}}, (bus.op1 < bus.op2)};
         default:  result_next = '0;
      endcase
   end

   alu_branch_cmp u_branch_cmp (
      .op1   (bus.op1),
      .op2   (bus.op2),
      .funct (bus.funct),
      .take  (take)
   );

   // A branch decision is only meaningful for the compare (SUB) operation;
   // the AND gating also keeps an undriven funct from leaking out otherwise.
   assign branch_next = (bus.ALUcntl == ALU_SUB) & take;

   // Output registers: valid follows in_valid, data holds when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.ALUResult <= '0;
         bus.ExeBranch <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.ALUResult <= result_next;
            bus.ExeBranch <= branch_next;
         end
      end
   end

`ifdef ALU_FLAGS_EN
   // Flags are taken from the same next-result so they track ALUResult exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.zero     <= 1'b0;
         bus.negative <= 1'b0;
      end else if (bus.in_valid) begin
         bus.zero     <= (result_next == '0);
         bus.negative <= result_next[XLEN-1];
      end
   end
`endif

endmodule

// File: tb/tb_rv32_alu.sv
// Testbench for rv32_alu: directed literal cases from the ALU's intended
// behaviour plus randomized traffic, all checked every cycle against a
// behavioural model. Also exercises the ALU_FLAGS_EN outputs when defined.
module tb_rv32_alu;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic checkEn = 1'b0;
   int   checks = 0;
   int   failures = 0;

   rv32_alu_if bus ();

   rv32_alu dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Reference ALU computed from the operation definitions with wide arithmetic.
   function automatic logic [31:0] modelAlu(logic [3:0] c, logic [31:0] a, logic [31:0] b);
      int unsigned     sh;
      longint unsigned wide;
      sh = b % 32;
      case (c)
         4'd0: return a & b;
         4'd1: return a | b;
         4'd2: return a ^ b;
         4'd3: begin wide = 64'(a) << sh; return wide[31:0]; end
         4'd4: return a >> sh;
         4'd5: begin wide = {{32{a[31]}}, a} >> sh; return wide[31:0]; end
         4'd6: begin wide = 64'(a) + 64'(b); return wide[31:0]; end
         4'd7: begin wide = 64'(a) + 64'(~b) + 64'd1; return wide[31:0]; end
         4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd9: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Reference branch decision: only the compare operation can take a branch.
   function automatic logic modelBranch(logic [3:0] c, logic [2:0] f, logic [31:0] a, logic [31:0] b);
      if (c !== 4'd7) return 1'b0;
      case (f)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return int'(a) <  int'(b);
         3'd5: return int'(a) >= int'(b);
         3'd6: return longint'(a) <  longint'(b);
         3'd7: return longint'(a) >= longint'(b);
         default: return 1'b0;
      endcase
   endfunction

   logic        mValid  = 1'b0;
   logic [31:0] mResult = 32'd0;
   logic        mBranch = 1'b0;

   // Model state: what the registered outputs must hold after each edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mValid  = 1'b0;
         mResult = 32'd0;
         mBranch = 1'b0;
      end else begin
         mValid = bus.in_valid;
         if (bus.in_valid) begin
            mResult = modelAlu(bus.ALUcntl, bus.op1, bus.op2);
            mBranch = modelBranch(bus.ALUcntl, bus.funct, bus.op1, bus.op2);
         end
      end
   end

   task automatic check1(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every-cycle comparison of the DUT outputs against the model.
   always @(negedge clk) begin
      if (checkEn) begin
         check1("model_out_valid", 32'(bus.out_valid), 32'(mValid));
         check1("model_ALUResult", bus.ALUResult, mResult);
         check1("model_ExeBranch", 32'(bus.ExeBranch), 32'(mBranch));
`ifdef ALU_FLAGS_EN
         check1("model_zero", 32'(bus.zero), 32'(mResult == 32'd0));
         check1("model_negative", 32'(bus.negative), 32'(mResult[31]));
`endif
      end
   end

   // Drive one valid operation shortly after a rising edge.
   task automatic applyStimulus(input logic [3:0] c, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk);
      #2;
      bus.in_valid = 1'b1;
      bus.ALUcntl  = c;
      bus.funct    = f;
      bus.op1      = a;
      bus.op2      = b;
   endtask

   task automatic idleCycle();
      @(posedge clk);
      #2;
      bus.in_valid = 1'b0;
   endtask

   // Wait for the registering edge, then compare against literal expectations.
   task automatic checkOutput(input string name, input logic [31:0] expRes, input logic expBr);
      @(posedge clk);
      @(negedge clk);
      check1({name, "_valid"}, 32'(bus.out_valid), 32'd1);
      check1({name, "_result"}, bus.ALUResult, expRes);
      check1({name, "_branch"}, 32'(bus.ExeBranch), 32'(expBr));
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.ALUcntl  = 4'd0;
      bus.funct    = 3'd0;
      bus.op1      = 32'd0;
      bus.op2      = 32'd0;
      #1 rst = 1'b1;
      checkEn = 1'b1;
      #1;
      check1("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check1("reset_ALUResult", bus.ALUResult, 32'd0);
      check1("reset_ExeBranch", 32'(bus.ExeBranch), 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;

      // Logic operations
      applyStimulus(4'b0000, 3'd0, 32'hF0F0F0F0, 32'h0F0F0F0F); checkOutput("and", 32'h00000000, 1'b0);
      applyStimulus(4'b0001, 3'd0, 32'hF0F0F0F0, 32'h0F0F0F0F); checkOutput("or",  32'hFFFFFFFF, 1'b0);
      applyStimulus(4'b0010, 3'd0, 32'hF0F0F0F0, 32'h0F0F0F0F); checkOutput("xor", 32'hFFFFFFFF, 1'b0);
      // Shifts, including ignored upper shift bits
      applyStimulus(4'b0011, 3'd0, 32'hF0F0F0F0, 32'd2);        checkOutput("sll",    32'hC3C3C3C0, 1'b0);
      applyStimulus(4'b0100, 3'd0, 32'hF0F0F0F0, 32'd2);        checkOutput("srl",    32'h3C3C3C3C, 1'b0);
      applyStimulus(4'b0101, 3'd0, 32'hF0F0F0F0, 32'd2);        checkOutput("sra",    32'hFC3C3C3C, 1'b0);
      applyStimulus(4'b0011, 3'd0, 32'hF0F0F0F0, 32'h00000022); checkOutput("sll_hi", 32'hC3C3C3C0, 1'b0);
      applyStimulus(4'b0100, 3'd0, 32'hF0F0F0F0, 32'h00000022); checkOutput("srl_hi", 32'h3C3C3C3C, 1'b0);
      applyStimulus(4'b0101, 3'd0, 32'hF0F0F0F0, 32'h00000022); checkOutput("sra_hi", 32'hFC3C3C3C, 1'b0);
      applyStimulus(4'b0101, 3'd0, 32'h80000001, 32'd0);        checkOutput("sra_0",  32'h80000001, 1'b0);
      // Arithmetic and compares
      applyStimulus(4'b0110, 3'd0, 32'd10, 32'd20);             checkOutput("add",      32'h0000001E, 1'b0);
      applyStimulus(4'b0111, 3'b010, 32'd10, 32'd20);           checkOutput("sub",      32'hFFFFFFF6, 1'b0);
      applyStimulus(4'b0110, 3'd0, 32'hFFFFFFFF, 32'd1);        checkOutput("add_wrap", 32'h00000000, 1'b0);
      applyStimulus(4'b1000, 3'd0, 32'hFFFFFFFF, 32'd1);        checkOutput("slt",      32'h00000001, 1'b0);
      applyStimulus(4'b1001, 3'd0, 32'hFFFFFFFF, 32'd1);        checkOutput("sltu",     32'h00000000, 1'b0);
      applyStimulus(4'b1100, 3'd0, 32'h12345678, 32'd9);        checkOutput("reserved", 32'h00000000, 1'b0);
      // Branch decisions on the compare operation
      applyStimulus(4'b0111, 3'b000, 32'd5, 32'd5);             checkOutput("beq",  32'h00000000, 1'b1);
      applyStimulus(4'b0111, 3'b001, 32'd5, 32'd10);            checkOutput("bne",  32'hFFFFFFFB, 1'b1);
      applyStimulus(4'b0111, 3'b100, 32'd5, 32'd10);            checkOutput("blt",  32'hFFFFFFFB, 1'b1);
      applyStimulus(4'b0111, 3'b101, 32'd10, 32'd5);            checkOutput("bge",  32'h00000005, 1'b1);
      applyStimulus(4'b0111, 3'b110, 32'd15, 32'd20);           checkOutput("bltu", 32'hFFFFFFFB, 1'b1);
      applyStimulus(4'b0111, 3'b111, 32'd25, 32'd20);           checkOutput("bgeu", 32'h00000005, 1'b1);
      applyStimulus(4'b0111, 3'b100, 32'h80000000, 32'h7FFFFFFF); checkOutput("blt_ovf", 32'h00000001, 1'b1);
      applyStimulus(4'b0111, 3'b101, 32'h80000000, 32'h7FFFFFFF); checkOutput("bge_ovf", 32'h00000001, 1'b0);
      applyStimulus(4'b0111, 3'b010, 32'd5, 32'd5);             checkOutput("b010", 32'h00000000, 1'b0);
      applyStimulus(4'b0110, 3'b000, 32'd5, 32'd5);             checkOutput("add_beq", 32'h0000000A, 1'b0);
      applyStimulus(4'b0110, 3'bxxx, 32'd5, 32'd5);             checkOutput("add_xfunct", 32'h0000000A, 1'b0);

      // Asynchronous reset in the middle of a valid stream
      applyStimulus(4'b0111, 3'b001, 32'd100, 32'd23);          checkOutput("pre_reset", 32'd77, 1'b1);
      @(posedge clk);
      #4 rst = 1'b1;
      #1;
      check1("async_rst_valid",  32'(bus.out_valid), 32'd0);
      check1("async_rst_result", bus.ALUResult, 32'd0);
      check1("async_rst_branch", 32'(bus.ExeBranch), 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check1("idle_valid",  32'(bus.out_valid), 32'd0);
         check1("idle_result", bus.ALUResult, 32'd0);
      end
      applyStimulus(4'b0110, 3'd0, 32'd1, 32'd2);
      idleCycle();
      @(negedge clk);
      check1("pulse_valid",  32'(bus.out_valid), 32'd1);
      check1("pulse_result", bus.ALUResult, 32'd3);
      @(negedge clk);
      check1("hold_valid",  32'(bus.out_valid), 32'd0);
      check1("hold_result", bus.ALUResult, 32'd3);

      // Randomized traffic, checked by the every-cycle model comparison
      for (int i = 0; i < 500; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         @(posedge clk);
         #2;
         a = $urandom();
         b = $urandom();
         case ($urandom_range(0, 5))
            0: a = 32'h80000000;
            1: b = a;
            2: b = 32'h7FFFFFFF;
            3: a = 32'hFFFFFFFF;
            default: ;
         endcase
         bus.in_valid = ($urandom_range(0, 9) < 8);
         bus.ALUcntl  = ($urandom_range(0, 3) == 0) ? 4'b0111 : 4'($urandom_range(0, 15));
         bus.funct    = 3'($urandom_range(0, 7));
         bus.op1      = a;
         bus.op2      = b;
      end
      idleCycle();
      repeat (3) @(negedge clk);
      checkEn = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rv32_alu.md
Name: rv32_alu

Overview:
- Registered RV32I execute-stage ALU.
- Computes the integer ALU result selected by ALUcntl, plus a branch-taken decision selected by funct (RV32I branch funct3).
- Sits between the decode/operand-select stage and the writeback/PC-select logic of the RV32I single-cycle-derived datapath.
- Outputs are registered: one-cycle latency.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands/controls valid this cycle
- funct  input  3  RV32I branch funct3; used only for ExeBranch
- op1  input  32  operand A (rs1)
- op2  input  32  operand B (rs2 or immediate)
- ALUcntl  input  4  operation select
- out_valid  output  1  ALUResult/ExeBranch hold the result of the previous valid input
- ALUResult  output  32  registered result
- ExeBranch  output  1  registered branch-taken flag

Behaviour:
- Reset:
  - asynchronous, active-high.
  - ALUResult=0, ExeBranch=0, out_valid=0 immediately.
  - Reset held mid-operation discards any in-flight result.
- Latency and hold:
  - On each rising clk with in_valid=1, results computed from the current inputs are registered; out_valid=1 the next cycle.
  - With in_valid=0: out_valid=0 next cycle; ALUResult and ExeBranch hold their previous values.
  - Back-to-back valid inputs are accepted every cycle; no stall and no ready signal.
- ALUcntl encoding, arithmetic mod 2^32:
  - 0000 AND
  - 0001 OR
  - 0010 XOR
  - 0011 SLL: op1 << op2[4:0]
  - 0100 SRL: logical right shift by op2[4:0]
  - 0101 SRA: arithmetic right shift by op2[4:0], sign bit replicated
  - 0110 ADD: op1+op2, carry discarded
  - 0111 SUB: op1−op2, borrow discarded
  - 1000 SLT: 1 if signed op1<op2, else 0
  - 1001 SLTU: 1 if unsigned op1<op2, else 0
  - 1010–1111: result 0
- Shift boundaries: op2[31:5] ignored; shift amount 0 returns op1 unchanged.
- ExeBranch:
  - Evaluated only when ALUcntl=0111 (SUB); otherwise 0.
  - Uses direct comparisons of op1 and op2, not the sign of the wrapped difference, so it is overflow-safe.
  - funct encoding:
    - 000 BEQ: op1==op2
    - 001 BNE: op1!=op2
    - 100 BLT: signed op1<op2
    - 101 BGE: signed op1>=op2
    - 110 BLTU: unsigned op1<op2
    - 111 BGEU: unsigned op1>=op2
    - 010 and 011: 0
  - An X/undriven funct with a non-SUB ALUcntl must not affect ExeBranch, which stays 0.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined, two extra registered outputs are added:
  - zero (1 bit): registered ALUResult==0.
  - negative (1 bit): registered ALUResult[31].
  - Both reset to 0 and are updated under the same in_valid rule as ALUResult.
- When undefined, the ports do not exist and the core behaviour is identical.

Decomposition:
- Shared package alu_pkg:
  - ALUcntl operation constants (AND..SLTU).
  - funct3 branch constants (BEQ, BNE, BLT, BGE, BLTU, BGEU).
  - XLEN constant.
- One combinational sub-module alu_branch_cmp: inputs op1, op2, funct; output take. Instantiated by rv32_alu and gated by ALUcntl==SUB.
- Result mux and registers live in rv32_alu.

Test Plan:
- Logic ops: op1=F0F0F0F0, op2=0F0F0F0F, in_valid=1.
  - AND → 00000000, OR → FFFFFFFF, XOR → FFFFFFFF.
  - Each result appears one cycle later with out_valid=1.
- Shifts: op1=F0F0F0F0, op2=2.
  - SLL → C3C3C3C0, SRL → 3C3C3C3C, SRA → FC3C3C3C.
  - op2=0000_0022 (amount 2) gives the same results.
- Arithmetic:
  - ADD 10+20 → 0000001E.
  - SUB 10−20 → FFFFFFF6.
  - ADD FFFFFFFF+1 → 00000000.
  - SLT(FFFFFFFF,1) → 1; SLTU(FFFFFFFF,1) → 0.
  - ALUcntl=1100 → 0.
- Branches with ALUcntl=0111:
  - BEQ(5,5)=1; BNE(5,10)=1; BLT(5,10)=1; BGE(10,5)=1; BLTU(15,20)=1; BGEU(25,20)=1.
  - BLT(80000000,7FFFFFFF)=1 (overflow case).
  - funct=010 → 0.
  - Any funct with ALUcntl=0110 → 0.
- Reset/hold:
  - Assert rst asynchronously mid-stream: outputs go to 0 before the next clk edge.
  - Deassert, apply in_valid=0 for 3 cycles: out_valid=0, outputs hold 0.
  - Then one valid ADD 1+2: out_valid pulses one cycle, result 3 holds afterwards.
